// File: rtl/lfsr_arbiter_if.sv
// Bundle of requester, delivery and LFSR-control signals for lfsr_arbiter.
// master = arbiter side, slave = requesters plus the external LFSR.
interface lfsr_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic            rnd_valid;
    logic [7:0]      rnd_data;
    logic            init_done;
    logic            busy;
    logic            lockup;
    logic            lfsr_reset;
    logic            lfsr_enable;
    logic            lfsr_ready;
    logic [7:0]      lfsr_value;

    modport master (
        input  req, lfsr_ready, lfsr_value,
        output gnt, rnd_valid, rnd_data, init_done, busy, lockup,
               lfsr_reset, lfsr_enable
    );

    modport slave (
        output req, lfsr_ready, lfsr_value,
        input  gnt, rnd_valid, rnd_data, init_done, busy, lockup,
               lfsr_reset, lfsr_enable
    );
endinterface

// File: rtl/lfsr_arbiter.sv
// Round-robin sharing of one external 8-bit LFSR: fill sequencing, STEPS shifts per grant, one-cycle delivery.
// Optional zero-state lockup detection is enabled with macro LFSR_ARB_LOCKUP_EN.
module lfsr_arbiter #(
    parameter int NREQ        = 4,
    parameter int STEPS       = 8,
    parameter int FILL_CYCLES = 8
) (
    input  logic           clk,
    input  logic           reset,
    lfsr_arbiter_if.master bus
);
    localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int FW = $clog2(FILL_CYCLES);
    localparam int SW = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [2:0] {
        S_INIT,
        S_WAIT_READY,
        S_IDLE,
        S_STEP,
        S_DELIVER
    } state_t;

    state_t          r_state;
    logic [FW-1:0]   r_fill_cnt;
    logic [SW-1:0]   r_step_cnt;
    logic [NREQ-1:0] r_gnt;
    logic [LW-1:0]   r_gnt_idx;
    logic [LW-1:0]   r_last;

    logic [LW-1:0]   w_win;
    logic            w_any;
    logic            w_abort;

    // Smallest rotation offset from last+1 wins; loop runs backwards so it overwrites last.
    always_comb begin : rr_search
        int idx;
        idx   = 0;
        w_win = '0;
        w_any = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = int'(r_last) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (bus.req[idx[LW-1:0]]) begin
                w_win = idx[LW-1:0];
                w_any = 1'b1;
            end
        end
    end

`ifdef LFSR_ARB_LOCKUP_EN
    logic r_lockup;

    assign w_abort = ((r_state == S_STEP) || (r_state == S_DELIVER)) &&
                     (bus.lfsr_value == 8'h00);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lockup <= 1'b0;
        end else if (w_abort) begin
            r_lockup <= 1'b1;
        end
    end

    assign bus.lockup = r_lockup;
`else
    assign w_abort    = 1'b0;
    assign bus.lockup = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_INIT;
            r_fill_cnt <= '0;
            r_step_cnt <= '0;
            r_gnt      <= '0;
            r_gnt_idx  <= '0;
            r_last     <= LW'(NREQ - 1);
        end else if (w_abort) begin
            // Aborted grant: refill, keep r_last so the same requester wins again.
            r_state    <= S_INIT;
            r_fill_cnt <= '0;
            r_step_cnt <= '0;
            r_gnt      <= '0;
        end else begin
            case (r_state)
                S_INIT: begin
                    if (r_fill_cnt == FW'(FILL_CYCLES - 1)) begin
                        r_fill_cnt <= '0;
                        r_state    <= S_WAIT_READY;
                    end else begin
                        r_fill_cnt <= r_fill_cnt + 1'b1;
                    end
                end
                S_WAIT_READY: begin
                    if (bus.lfsr_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (w_any) begin
                        r_gnt      <= NREQ'(1) << w_win;
                        r_gnt_idx  <= w_win;
                        r_step_cnt <= '0;
                        r_state    <= S_STEP;
                    end
                end
                S_STEP: begin
                    if (r_step_cnt == SW'(STEPS - 1)) begin
                        r_step_cnt <= '0;
                        r_state    <= S_DELIVER;
                    end else begin
                        r_step_cnt <= r_step_cnt + 1'b1;
                    end
                end
                S_DELIVER: begin
                    r_gnt   <= '0;
                    r_last  <= r_gnt_idx;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_gnt   <= '0;
                    r_state <= S_INIT;
                end
            endcase
        end
    end

    assign bus.gnt         = r_gnt;
    assign bus.rnd_valid   = (r_state == S_DELIVER) && !w_abort;
    assign bus.rnd_data    = bus.rnd_valid ? bus.lfsr_value : 8'h00;
    assign bus.lfsr_reset  = (r_state == S_INIT);
    assign bus.lfsr_enable = (r_state == S_STEP);
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.init_done   = (r_state == S_IDLE) || (r_state == S_STEP) ||
                             (r_state == S_DELIVER);
endmodule

// File: tb/tb_lfsr_arbiter.sv
// Directed bench for lfsr_arbiter with a Galois LFSR model (TAPS 8'h1D) and a delivery scoreboard.
// Build with +define+LFSR_ARB_LOCKUP_EN to exercise the zero-state abort path.
module tb_lfsr_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic force_zero = 1'b0;
    logic [7:0] lfsr_q = 8'h00;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [3:0] g;
        logic [7:0] d;
    } exp_t;
    exp_t exp_q[$];

    lfsr_arbiter_if #(.NREQ(4)) bus ();

    lfsr_arbiter #(
        .NREQ(4),
        .STEPS(8),
        .FILL_CYCLES(8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // External LFSR: fill shifts in ones, enable does a left Galois step.
    always @(posedge clk) begin
        if (bus.lfsr_reset) begin
            lfsr_q <= {lfsr_q[6:0], 1'b1};
        end else if (bus.lfsr_enable) begin
            lfsr_q <= {lfsr_q[6:0], 1'b0} ^ (lfsr_q[7] ? 8'h1D : 8'h00);
        end
    end
    assign bus.lfsr_value = force_zero ? 8'h00 : lfsr_q;
    assign bus.lfsr_ready = (bus.lfsr_value == 8'hFF);

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.rnd_valid === 1'b1) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_delivery: gnt=%b data=%h, required no delivery",
                             bus.gnt, bus.rnd_data);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.gnt !== e.g || bus.rnd_data !== e.d) begin
                        n_err++;
                        $display("FAIL delivery: gnt=%b data=%h, required gnt=%b data=%h",
                                 bus.gnt, bus.rnd_data, e.g, e.d);
                    end else begin
                        $display("deliver gnt=%b data=%h", bus.gnt, bus.rnd_data);
                    end
                end
            end
        end
    endtask

    // Reset for one edge, release, then walk cycles 0..9; returns at cycle 9 (IDLE).
    task automatic init_seq();
        reset = 1'b1;
        tick(1);
        check("rst_gnt", bus.gnt, 0);
        check("rst_valid", bus.rnd_valid, 0);
        check("rst_data", bus.rnd_data, 0);
        check("rst_init_done", bus.init_done, 0);
        check("rst_busy", bus.busy, 1);
        check("rst_lockup", bus.lockup, 0);
        check("rst_enable", bus.lfsr_enable, 0);
        check("rst_lfsr_reset", bus.lfsr_reset, 1);
        reset = 1'b0;
        for (int c = 0; c <= 9; c++) begin
            if (c > 0) tick(1);
            check("init_lfsr_reset", bus.lfsr_reset, (c < 8) ? 1 : 0);
            check("init_done", bus.init_done, (c >= 9) ? 1 : 0);
            check("init_busy", bus.busy, (c < 9) ? 1 : 0);
        end
    endtask

    initial begin
        logic [3:0] eg;
        bus.req = 4'b0000;
        fork
            monitor();
        join_none
        tick(2);

        // Single request from index 1
        init_seq();
        bus.req = 4'b0010;
        exp_q.push_back({4'b0010, 8'hC4});
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            if (k == 1) bus.req = 4'b0000;
            check("single_gnt", bus.gnt, (k <= 9) ? 4'b0010 : 4'b0000);
            check("single_enable", bus.lfsr_enable, (k <= 8) ? 1 : 0);
            check("single_valid", bus.rnd_valid, (k == 9) ? 1 : 0);
            check("single_data", bus.rnd_data, (k == 9) ? 8'hC4 : 8'h00);
        end

        // Fairness with all requests held from reset
        bus.req = 4'b1111;
        init_seq();
        exp_q.push_back({4'b0001, 8'hC4});
        exp_q.push_back({4'b0010, 8'h41});
        exp_q.push_back({4'b0100, 8'h0E});
        exp_q.push_back({4'b1000, 8'hA6});
        exp_q.push_back({4'b0001, 8'hEF});
        for (int c = 10; c <= 58; c++) begin
            tick(1);
            eg = (((c - 10) % 10) < 9) ? (4'b0001 << (((c - 10) / 10) % 4)) : 4'b0000;
            check("fair_gnt", bus.gnt, eg);
        end
        bus.req = 4'b0000;
        tick(1);
        check("fair_tail_gnt", bus.gnt, 0);
        check("fair_tail_busy", bus.busy, 0);
        tick(1);
        check("fair_no_extra", bus.gnt, 0);

        // Request dropped after grant, then pointer resumes after index 2
        init_seq();
        bus.req = 4'b0100;
        exp_q.push_back({4'b0100, 8'hC4});
        tick(1);
        check("drop_gnt", bus.gnt, 4'b0100);
        bus.req = 4'b0000;
        tick(8);
        check("drop_valid", bus.rnd_valid, 1);
        check("drop_gnt_held", bus.gnt, 4'b0100);
        tick(1);
        check("drop_idle_busy", bus.busy, 0);
        check("drop_idle_gnt", bus.gnt, 0);
        bus.req = 4'b1001;
        exp_q.push_back({4'b1000, 8'h41});
        tick(1);
        check("rr_after_2", bus.gnt, 4'b1000);
        bus.req = 4'b0000;
        tick(10);

        // Reset during the 4th STEP cycle
        init_seq();
        bus.req = 4'b0010;
        exp_q.push_back({4'b0010, 8'hC4});
        tick(1);
        bus.req = 4'b0000;
        tick(9);
        bus.req = 4'b0111;
        tick(1);
        check("mid_first_gnt", bus.gnt, 4'b0100);
        tick(3);
        reset = 1'b1;
        tick(1);
        check("mid_rst_gnt", bus.gnt, 0);
        check("mid_rst_lfsr_reset", bus.lfsr_reset, 1);
        check("mid_rst_enable", bus.lfsr_enable, 0);
        check("mid_rst_busy", bus.busy, 1);
        check("mid_rst_valid", bus.rnd_valid, 0);
        init_seq();
        exp_q.push_back({4'b0001, 8'hC4});
        tick(1);
        check("mid_regrant_0", bus.gnt, 4'b0001);
        bus.req = 4'b0000;
        tick(10);

        // Zero LFSR value seen during STEP
        init_seq();
        bus.req = 4'b0110;
`ifdef LFSR_ARB_LOCKUP_EN
        tick(3);
        force_zero = 1'b1;
        tick(1);
        force_zero = 1'b0;
        check("lock_flag", bus.lockup, 1);
        check("lock_gnt", bus.gnt, 0);
        check("lock_lfsr_reset", bus.lfsr_reset, 1);
        check("lock_valid", bus.rnd_valid, 0);
        tick(10);
        exp_q.push_back({4'b0010, 8'hC4});
        check("lock_regrant", bus.gnt, 4'b0010);
        check("lock_sticky", bus.lockup, 1);
        bus.req = 4'b0000;
        tick(10);
`else
        exp_q.push_back({4'b0010, 8'hC4});
        tick(3);
        force_zero = 1'b1;
        tick(1);
        force_zero = 1'b0;
        check("nolock_flag", bus.lockup, 0);
        check("nolock_gnt", bus.gnt, 4'b0010);
        check("nolock_lfsr_reset", bus.lfsr_reset, 0);
        bus.req = 4'b0000;
        tick(7);
`endif

        tick(3);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "timeout");
    end
endmodule
